fpu_share_arbiter: RTL and testbench
====================================

Name: fpu_share_arbiter

Overview:
Shares one fpnew_top instance between NumReq requesters with independent valid/ready request and response channels. Arbitration is round-robin. The grant index travels through the FPU as tag_i, and tag_o routes each result back to its issuer. A credit counter caps in-flight operations so that FPU back-pressure never deadlocks the shared pipeline.

Parameters:
NumReq, 4, number of requesters (>= 2)
MaxInflight, 8, max operations accepted by FPU and not yet returned (>= 1)
IdW, $clog2(NumReq), tag width; the FPU is instantiated with a matching TagType
CntW, $clog2(MaxInflight+1), in-flight counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester request accepted
req_op_i  in  NumReq x fpu_req_t  operands[3][64], rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt, vectorial_op
resp_valid_o  out  NumReq  result valid for requester k
resp_ready_i  in  NumReq  requester k accepts result
resp_result_o  out  64  shared result bus
resp_status_o  out  5  shared fpnew status_t
flush_i  in  1  abort all in-flight work
fpu_req_o  out  fpu_req_t  to FPU operand/op fields
fpu_tag_o  out  IdW  to FPU tag_i
fpu_in_valid_o  out  1  to FPU in_valid_i
fpu_in_ready_i  in  1  from FPU in_ready_o
fpu_result_i  in  64  from FPU result_o
fpu_status_i  in  5  from FPU status_o
fpu_tag_i  in  IdW  from FPU tag_o
fpu_out_valid_i  in  1  from FPU out_valid_o
fpu_out_ready_o  out  1  to FPU out_ready_i
fpu_flush_o  out  1  to FPU flush_i
busy_o  out  1  in-flight count non-zero

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - rr pointer resets to 0; inflight count resets to 0.
  - Every output is low or zero once rst_i is sampled. Combinational outputs are zero because the count is 0 and the FPU side is idle.
- Issue path is combinational, with zero added latency.
  - can_issue = (inflight < MaxInflight) && !flush_i.
  - grant = first asserted req_valid_i at or after the pointer, scanning upward with wrap from NumReq-1 to 0.
  - fpu_in_valid_o = can_issue && |req_valid_i.
  - fpu_req_o = req_op_i[grant]; fpu_tag_o = grant.
  - req_ready_o[grant] = can_issue && fpu_in_ready_i; all other req_ready_o bits are 0.
- Pointer update: on an issue handshake (fpu_in_valid_o && fpu_in_ready_i), the pointer becomes (grant+1) mod NumReq. With no handshake, the pointer holds.
- Response path is combinational.
  - resp_valid_o[k] = fpu_out_valid_i && (fpu_tag_i == k).
  - resp_result_o = fpu_result_i; resp_status_o = fpu_status_i.
  - fpu_out_ready_o = resp_ready_i[fpu_tag_i].
  - If requester fpu_tag_i is not ready, the whole FPU output stalls. This head-of-line stall is accepted.
- Inflight counter:
  - +1 on an issue handshake; -1 on a response handshake (fpu_out_valid_i && fpu_out_ready_o).
  - Both in the same cycle: unchanged.
  - At MaxInflight, no issue. A response in that same cycle does not re-enable issue until the next cycle (no combinational path from response to issue).
- Tag out of range (fpu_tag_i >= NumReq, non-power-of-2 NumReq only): no resp_valid_o asserted, fpu_out_ready_o = 1 (drop). Count is still decremented. A simulation assertion fires.
- Flush:
  - fpu_flush_o = flush_i.
  - During the flush cycle: no issue, all req_ready_o = 0, resp_valid_o forced 0, fpu_out_ready_o = 1.
  - The counter clears to 0 at the next edge.
- Reset mid-operation: the counter and pointer clear and no responses are routed. The integrator ties fpu_flush_o | rst_i into the FPU so nothing stale returns.
- busy_o = (inflight != 0), registered-count based.

Optional Feature:
FPU_ARB_PERF_EN
- Defined: per-requester 32-bit grant counters and a 32-bit stall counter are added.
  - The stall counter counts cycles with |req_valid_i && !fpu_in_valid_o, or with fpu_in_valid_o && !fpu_in_ready_i.
  - All counters saturate and clear on rst_i.
  - Extra ports: perf_grants_o (NumReq x 32) and perf_stalls_o (32).
- Undefined: neither the ports nor the logic exist.

Decomposition:
- Package fpu_arb_pkg:
  - fpu_req_t packed struct, built on fpnew_pkg enums (roundmode_e, operation_e, fp_format_e, int_format_e).
  - FpuWidth=64 and StatusW=5 constants.
- One sub-module, rr_arbiter: NumReq-wide valid vector plus pointer in, one-hot/index grant out, purely combinational. The pointer register lives in the parent.

Test Plan:
- Only req 0 valid, FP32 ADD 0x3f800000+0x3f800000 RNE -> resp_valid_o[0] only, result 0x40000000, status 0, busy_o returns to 0.
- Reqs 0 and 2 valid together for 3 handshakes, pointer 0 -> grants in order 0, 2, 0; each result returns on its own resp_valid_o bit.
- MaxInflight=2, resp_ready_i all 0, three requests -> first two accepted, third req_ready_o=0 with busy_o=1. Raise resp_ready_i -> one response, third accepted the following cycle.
- Req1 result pending with resp_ready_i[1]=0 -> fpu_out_ready_o=0 and the FPU stalls. Raise resp_ready_i[1] -> result delivered, count decrements by 1.
- flush_i pulsed with 3 in flight -> fpu_flush_o=1 that cycle, no req_ready_o, counter=0 and busy_o=0 next cycle; later FP16 ADD 0x4900+0x4d00 RTZ -> 0x4f80.
- rst_i asserted for 1 cycle with 2 in flight -> outputs zero, pointer 0, counter 0. With FPU_ARB_PERF_EN defined, all counters read 0.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_arb_pkg
// Description : Shared types for the FPU sharing arbiter. The request struct
//               carries every operand/op field an fpnew_top instance takes.
//               The enum encodings mirror fpnew_pkg bit-for-bit, so a request
//               can be cast straight onto the FPU input fields.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_arb_pkg;

    localparam int FpuWidth = 64;
    localparam int StatusW  = 5;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8, INT16, INT32, INT64
    } int_format_e;

    typedef struct packed {
        logic [2:0][FpuWidth-1:0] operands;
        roundmode_e               rnd_mode;
        operation_e               op;
        logic                     op_mod;
        fp_format_e               src_fmt;
        fp_format_e               dst_fmt;
        int_format_e              int_fmt;
        logic                     vectorial_op;
    } fpu_req_t;

endpackage : fpu_arb_pkg
`default_nettype wire

// File: rtl/fpu_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Grants the first asserted
//               valid at or after i_ptr, scanning upward and wrapping from
//               NumReq-1 to 0. The pointer register lives in the parent.
// Ports       : i_valid     - request vector
//               i_ptr       - scan start index (< NumReq)
//               o_grant_oh  - one-hot grant (zero when nothing valid)
//               o_grant_idx - binary grant index (zero when nothing valid)
//               o_any       - any request valid
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NumReq = 4,
    parameter int IdW    = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] i_valid,
    input  logic [IdW-1:0]    i_ptr,
    output logic [NumReq-1:0] o_grant_oh,
    output logic [IdW-1:0]    o_grant_idx,
    output logic              o_any
);

    logic [IdW:0]   w_sum;
    logic [IdW-1:0] w_idx;
    logic           w_found;

    assign o_any = |i_valid;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int off = 0; off < NumReq; off++) begin
            // (ptr + off) mod NumReq without a divider: one conditional subtract
            w_sum = {1'b0, i_ptr} + (IdW+1)'(off);
            if (w_sum >= (IdW+1)'(NumReq)) begin
                w_sum = w_sum - (IdW+1)'(NumReq);
            end
            w_idx = w_sum[IdW-1:0];
            if (!w_found && i_valid[w_idx]) begin
                w_found            = 1'b1;
                o_grant_oh[w_idx]  = 1'b1;
                o_grant_idx        = w_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fpu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_share_arbiter
// Description : Shares one fpnew_top between NumReq requesters. Round-robin
//               issue, grant index carried through the FPU as its tag and
//               used to route each result back. An in-flight credit counter
//               caps outstanding operations at MaxInflight.
// Ports       : req_*     - per-requester request channel (valid/ready/op)
//               resp_*    - per-requester response valid/ready, shared bus
//               fpu_*     - connection to the shared FPU
//               flush_i   - abort all in-flight work (forwarded to FPU)
//               busy_o    - in-flight count non-zero
// Option      : FPU_ARB_PERF_EN adds saturating grant/stall counters and the
//               perf_grants_o / perf_stalls_o ports.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NumReq      = 4,
    parameter int MaxInflight = 8,
    parameter int IdW         = $clog2(NumReq),
    parameter int CntW        = $clog2(MaxInflight+1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    input  fpu_req_t [NumReq-1:0]      req_op_i,
    output logic [NumReq-1:0]          resp_valid_o,
    input  logic [NumReq-1:0]          resp_ready_i,
    output logic [FpuWidth-1:0]        resp_result_o,
    output logic [StatusW-1:0]         resp_status_o,
    input  logic                       flush_i,
    output fpu_req_t                   fpu_req_o,
    output logic [IdW-1:0]             fpu_tag_o,
    output logic                       fpu_in_valid_o,
    input  logic                       fpu_in_ready_i,
    input  logic [FpuWidth-1:0]        fpu_result_i,
    input  logic [StatusW-1:0]         fpu_status_i,
    input  logic [IdW-1:0]             fpu_tag_i,
    input  logic                       fpu_out_valid_i,
    output logic                       fpu_out_ready_o,
    output logic                       fpu_flush_o,
`ifdef FPU_ARB_PERF_EN
    output logic [NumReq-1:0][31:0]    perf_grants_o,
    output logic [31:0]                perf_stalls_o,
`endif
    output logic                       busy_o
);

    logic [IdW-1:0]    r_ptr;
    logic [CntW-1:0]   r_cnt;

    logic [NumReq-1:0] w_grant_oh;
    logic [IdW-1:0]    w_grant_idx;
    logic              w_any_valid;
    logic              w_can_issue;
    logic              w_issue_hs;
    logic              w_resp_hs;
    logic [NumReq-1:0] w_tag_oh;
    logic              w_tag_known;
    logic              w_sel_ready;

    rr_arbiter #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_rr (
        .i_valid     (req_valid_i),
        .i_ptr       (r_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any_valid)
    );

    // ---------------- issue path ----------------
    // Credit check uses only the registered count, so a response in the same
    // cycle never opens the issue gate combinationally.
    assign w_can_issue    = !rst_i && !flush_i && (r_cnt < CntW'(MaxInflight));
    assign fpu_in_valid_o = w_can_issue && w_any_valid;
    assign fpu_req_o      = req_op_i[w_grant_idx];
    assign fpu_tag_o      = w_grant_idx;
    assign req_ready_o    = (w_can_issue && fpu_in_ready_i) ? w_grant_oh : '0;
    assign w_issue_hs     = fpu_in_valid_o && fpu_in_ready_i;

    // ---------------- response path ----------------
    // Decoding the tag by compare keeps non-power-of-2 NumReq safe: an
    // out-of-range tag matches no requester and is simply dropped.
    always_comb begin
        w_tag_oh    = '0;
        w_tag_known = 1'b0;
        w_sel_ready = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            if (fpu_tag_i == IdW'(k)) begin
                w_tag_oh[k] = 1'b1;
                w_tag_known = 1'b1;
                w_sel_ready = resp_ready_i[k];
            end
        end
    end

    assign resp_valid_o    = (fpu_out_valid_i && !flush_i && !rst_i) ? w_tag_oh : '0;
    assign fpu_out_ready_o = !rst_i && (flush_i || !w_tag_known || w_sel_ready);
    assign resp_result_o   = fpu_result_i;
    assign resp_status_o   = fpu_status_i;
    assign w_resp_hs       = fpu_out_valid_i && fpu_out_ready_o;

    assign fpu_flush_o     = flush_i;
    assign busy_o          = (r_cnt != '0);

    // ---------------- pointer and credit counter ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            if (w_issue_hs) begin
                r_ptr <= (w_grant_idx == IdW'(NumReq-1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (flush_i) begin
                r_cnt <= '0;
            end else if (w_issue_hs && !w_resp_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_issue_hs && w_resp_hs && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_tag_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        fpu_out_valid_i |-> w_tag_known);
`endif

`ifdef FPU_ARB_PERF_EN
    logic [NumReq-1:0][31:0] r_grants;
    logic [31:0]             r_stalls;
    logic                    w_stall;

    assign w_stall = (w_any_valid && !fpu_in_valid_o) || (fpu_in_valid_o && !fpu_in_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grants <= '0;
            r_stalls <= '0;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                if (w_issue_hs && w_grant_oh[k] && (r_grants[k] != '1)) begin
                    r_grants[k] <= r_grants[k] + 32'd1;
                end
            end
            if (w_stall && (r_stalls != '1)) begin
                r_stalls <= r_stalls + 32'd1;
            end
        end
    end

    assign perf_grants_o = r_grants;
    assign perf_stalls_o = r_stalls;
`endif

endmodule : fpu_share_arbiter
`default_nettype wire

// File: tb/tb_fpu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_share_arbiter
// Description : Self-checking bench. A stub FPU (in-order, random latency,
//               random input back-pressure) sits on the FPU side; a
//               transaction-level model predicts grants, credits and the
//               result each requester must receive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_share_arbiter;
    import fpu_arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXF = 2;
    localparam int IW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid, req_ready, resp_valid, resp_ready;
    fpu_req_t [N-1:0]     req_op;
    logic [63:0]          resp_result;
    logic [4:0]           resp_status;
    logic                 flush;
    fpu_req_t             fpu_req;
    logic [IW-1:0]        fpu_tag_out, fpu_tag_in;
    logic                 fpu_in_valid, fpu_in_ready;
    logic [63:0]          fpu_result;
    logic [4:0]           fpu_status;
    logic                 fpu_out_valid, fpu_out_ready, fpu_flush, busy;
`ifdef FPU_ARB_PERF_EN
    logic [N-1:0][31:0]   perf_grants;
    logic [31:0]          perf_stalls;
    int                   m_grants [N];
    int                   m_stalls;
`endif

    always #5 clk = ~clk;

    fpu_share_arbiter #(.NumReq(N), .MaxInflight(MAXF)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_result_o  (resp_result),
        .resp_status_o  (resp_status),
        .flush_i        (flush),
        .fpu_req_o      (fpu_req),
        .fpu_tag_o      (fpu_tag_out),
        .fpu_in_valid_o (fpu_in_valid),
        .fpu_in_ready_i (fpu_in_ready),
        .fpu_result_i   (fpu_result),
        .fpu_status_i   (fpu_status),
        .fpu_tag_i      (fpu_tag_in),
        .fpu_out_valid_i(fpu_out_valid),
        .fpu_out_ready_o(fpu_out_ready),
        .fpu_flush_o    (fpu_flush),
`ifdef FPU_ARB_PERF_EN
        .perf_grants_o  (perf_grants),
        .perf_stalls_o  (perf_stalls),
`endif
        .busy_o         (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stub FPU arithmetic: two exact IEEE cases, a reversible mix otherwise.
    function automatic logic [63:0] golden(input fpu_req_t r);
        if (r.op == ADD && r.src_fmt == FP32 && r.rnd_mode == RNE &&
            r.operands[0] == 64'h3f800000 && r.operands[1] == 64'h3f800000)
            return 64'h40000000;
        if (r.op == ADD && r.src_fmt == FP16 && r.rnd_mode == RTZ &&
            r.operands[0] == 64'h4900 && r.operands[1] == 64'h4d00)
            return 64'h4f80;
        return r.operands[0] ^ {r.operands[1][31:0], r.operands[1][63:32]} ^
               r.operands[2] ^ {59'd0, r.rnd_mode, r.op[1:0]};
    endfunction

    function automatic fpu_req_t rand_op();
        fpu_req_t r;
        r.operands[0]  = {$urandom, $urandom};
        r.operands[1]  = {$urandom, $urandom};
        r.operands[2]  = {$urandom, $urandom};
        r.rnd_mode     = roundmode_e'($urandom_range(0, 4));
        r.op           = operation_e'($urandom_range(0, 14));
        r.op_mod       = 1'($urandom_range(0, 1));
        r.src_fmt      = fp_format_e'($urandom_range(0, 4));
        r.dst_fmt      = fp_format_e'($urandom_range(0, 4));
        r.int_fmt      = int_format_e'($urandom_range(0, 3));
        r.vectorial_op = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic fpu_req_t add_op(input fp_format_e f, input roundmode_e rm,
                                        input logic [63:0] a, input logic [63:0] b);
        fpu_req_t r;
        r = '0;
        r.op = ADD; r.src_fmt = f; r.dst_fmt = f; r.rnd_mode = rm;
        r.operands[0] = a; r.operands[1] = b;
        return r;
    endfunction

    // Reference model: credits, next-scan start, expected response order.
    typedef struct { int tag; logic [63:0] res; } exp_t;
    typedef struct { logic [IW-1:0] tag; logic [63:0] res; int rdy; } stub_t;
    exp_t  m_q[$];
    stub_t s_q[$];
    int    m_cnt   = 0;
    int    m_start = 0;

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = '0; flush = 1'b0;
        fpu_in_ready = 1'b0; fpu_out_valid = 1'b0; fpu_tag_in = '0;
        fpu_result = '0; fpu_status = '0;
        @(posedge clk); #1;
        chk("rst_in_valid", fpu_in_valid, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_out_ready", fpu_out_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flush", fpu_flush, 1'b0);
`ifdef FPU_ARB_PERF_EN
        chk("rst_perf_grants", perf_grants, '0);
        chk("rst_perf_stalls", perf_stalls, '0);
        foreach (m_grants[k]) m_grants[k] = 0;
        m_stalls = 0;
`endif
        rst = 1'b0;
        m_q.delete(); s_q.delete(); m_cnt = 0; m_start = 0;
    endtask

    task automatic step(input logic [N-1:0] vld, input logic [N-1:0] rrdy,
                        input logic inrdy, input logic fl);
        int g;
        logic ev, sv, exp_ordy, iss, rsp, got_iv, got_ordy;
        logic [N-1:0] exp_rdy, exp_rv;
        fpu_req_t got_req;
        logic [IW-1:0] got_tag;
        req_valid = vld; resp_ready = rrdy; fpu_in_ready = inrdy; flush = fl;
        sv = (s_q.size() != 0) && (s_q[0].rdy <= cyc);
        fpu_out_valid = sv;
        fpu_tag_in    = sv ? s_q[0].tag : '0;
        fpu_result    = sv ? s_q[0].res : '0;
        fpu_status    = sv ? s_q[0].res[4:0] : '0;
        @(negedge clk);
        g = -1;
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_start + o) % N;
            if (g < 0 && vld[k]) g = k;
        end
        ev = (m_cnt < MAXF) && !fl && (g >= 0);
        exp_rdy = '0;
        if (ev && inrdy) exp_rdy[g] = 1'b1;
        chk("in_valid", fpu_in_valid, ev);
        if (ev) begin
            chk("grant_tag", fpu_tag_out, g);
            chk("fpu_req", fpu_req, req_op[g]);
        end
        chk("req_ready", req_ready, exp_rdy);
        exp_rv = '0;
        if (sv && !fl) exp_rv[s_q[0].tag] = 1'b1;
        chk("resp_valid", resp_valid, exp_rv);
        exp_ordy = fl ? 1'b1 : rrdy[fpu_tag_in];
        if (sv || fl) chk("out_ready", fpu_out_ready, exp_ordy);
        chk("flush_o", fpu_flush, fl);
        chk("busy", busy, m_cnt != 0);
        iss = ev && inrdy;
        rsp = sv && exp_ordy;
        if (rsp && !fl) begin
            if (m_q.size() == 0) begin
                chk("resp_orphan", 1'b1, 1'b0);
            end else begin
                chk("resp_tag", s_q[0].tag, m_q[0].tag);
                chk("resp_result", resp_result, m_q[0].res);
                chk("resp_status", resp_status, m_q[0].res[4:0]);
            end
        end
`ifdef FPU_ARB_PERF_EN
        if (iss) m_grants[g]++;
        if (((|vld) && !ev) || (ev && !inrdy)) m_stalls++;
`endif
        got_iv = fpu_in_valid; got_req = fpu_req; got_tag = fpu_tag_out;
        got_ordy = fpu_out_ready;
        @(posedge clk);
        cyc++;
        if (fl) begin
            m_q.delete(); m_cnt = 0; s_q.delete();
        end else begin
            if (rsp && m_q.size() != 0) void'(m_q.pop_front());
            if (iss) begin
                m_q.push_back('{tag: g, res: golden(req_op[g])});
                m_start = (g + 1) % N;
            end
            m_cnt = m_cnt + int'(iss) - int'(rsp);
            if (sv && got_ordy) void'(s_q.pop_front());
            if (got_iv && inrdy)
                s_q.push_back('{tag: got_tag, res: golden(got_req),
                                rdy: cyc + int'($urandom_range(0, 3))});
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (m_cnt != 0 || s_q.size() != 0); i++)
            step('0, '1, 1'b1, 1'b0);
        @(negedge clk);
        chk("drain_busy", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) req_op[k] = rand_op();
        do_reset();

        // single requester, FP32 1.0 + 1.0
        req_op[0] = add_op(FP32, RNE, 64'h3f800000, 64'h3f800000);
        step(4'b0001, 4'b1111, 1'b1, 1'b0);
        drain();

        // requesters 0 and 2 from pointer 0
        do_reset();
        req_op[0] = rand_op(); req_op[2] = rand_op();
        repeat (4) step(4'b0101, 4'b1111, 1'b1, 1'b0);
        drain();

        // credit cap with responses blocked, then release
        repeat (4) step(4'b0111, 4'b0000, 1'b1, 1'b0);
        repeat (3) step(4'b0111, 4'b1111, 1'b1, 1'b0);
        drain();

        // head-of-line stall on requester 1
        req_op[1] = rand_op();
        step(4'b0010, 4'b1101, 1'b1, 1'b0);
        repeat (5) step(4'b0000, 4'b1101, 1'b1, 1'b0);
        drain();

        // flush with work in flight, then FP16 10 + 20
        repeat (2) step(4'b1111, 4'b0000, 1'b1, 1'b0);
        step(4'b1111, 4'b0000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        req_op[3] = add_op(FP16, RTZ, 64'h4900, 64'h4d00);
        step(4'b1000, 4'b1111, 1'b1, 1'b0);
        drain();

        // reset mid-operation
        repeat (2) step(4'b1111, 4'b0000, 1'b1, 1'b0);
        do_reset();
        step(4'b1111, 4'b1111, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < N; k++) req_op[k] = rand_op();
            if ($urandom_range(0, 799) == 0) do_reset();
            else step(N'($urandom), N'($urandom | $urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
        end
        drain();
`ifdef FPU_ARB_PERF_EN
        for (int k = 0; k < N; k++) chk("perf_grants", perf_grants[k], m_grants[k]);
        chk("perf_stalls", perf_stalls, m_stalls);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fpu_share_arbiter
`default_nettype wire
